// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, sequencer states
// and the default datapath width.
package mdu_pkg;

    localparam int BITS_DEFAULT = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        ITER  = 2'd2,
        FIXUP = 2'd3
    } div_state_t;

endpackage

// File: rtl/mdu_div_controller_if.sv
// Execute-stage <-> divide sequencer bundle: op issue, flush, HI/LO read port and
// status back to the pipeline.
interface mdu_div_controller_if
    import mdu_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
);
    logic            op_valid;
    logic [1:0]      op_code;
    logic [BITS-1:0] op_a;
    logic [BITS-1:0] op_b;
    logic            flush;
    logic            rd_req;
    logic            rd_sel;
    logic [BITS-1:0] rd_data;
    logic [BITS-1:0] hi;
    logic [BITS-1:0] lo;
    logic            busy;
    logic            stall;
    logic            div_by_zero;

    modport master (
        output op_valid, op_code, op_a, op_b, flush, rd_req, rd_sel,
        input  rd_data, hi, lo, busy, stall, div_by_zero
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush, rd_req, rd_sel,
        output rd_data, hi, lo, busy, stall, div_by_zero
    );
endinterface

// File: rtl/div_step_unit.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract the
// divisor when it fits, and shift the resulting quotient bit in.
module div_step_unit #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] rem_in,
    input  logic [BITS-1:0] quo_in,
    input  logic            dividend_bit,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] rem_out,
    output logic [BITS-1:0] quo_out
);
    logic [BITS:0]   shifted;
    logic [BITS-1:0] diff;
    logic            fits;
    logic            unused_quo_msb;

    // The shifted partial remainder needs one extra bit before the compare.
    assign shifted = {rem_in, dividend_bit};
    assign fits    = shifted >= {1'b0, divisor};
    assign diff    = shifted[BITS-1:0] - divisor;

    assign rem_out = fits ? diff : shifted[BITS-1:0];
    assign quo_out = {quo_in[BITS-2:0], fits};

    assign unused_quo_msb = quo_in[BITS-1];
endmodule

// File: rtl/mdu_div_controller.sv
// Iterative restoring divider sequencer for DIV/DIVU plus MTHI/MTLO; owns the HI/LO
// architectural registers and raises stall while a divide is in flight.
module mdu_div_controller
    import mdu_pkg::*;
#(
    parameter int BITS        = BITS_DEFAULT,
    parameter int COUNT_WIDTH = $clog2(BITS) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    mdu_div_controller_if.slave  bus
);
    div_state_t             state, state_nxt;
    logic [COUNT_WIDTH-1:0] count;
    logic [BITS-1:0]        hi_r, lo_r;
    logic                   dz_r;

    logic [BITS-1:0]        dvd, dvs, quo, rem;
    logic [BITS-1:0]        rem_step, quo_step;
    logic                   q_neg, r_neg;

    logic                   accept, acc_div, is_signed, last_iter, dz, writeback;

    function automatic logic [BITS-1:0] magnitude(input logic signed [BITS-1:0] v,
                                                  input logic               en);
        logic signed [BITS-1:0] neg_v;
        neg_v = -v;
        return (en && v[BITS-1]) ? $unsigned(neg_v) : $unsigned(v);
    endfunction

    function automatic logic [BITS-1:0] apply_sign(input logic [BITS-1:0] v,
                                                   input logic            neg);
        return neg ? ('0 - v) : v;
    endfunction

    assign accept    = bus.op_valid && (state == IDLE) && !bus.flush;
    assign acc_div   = accept && !bus.op_code[1];
    assign is_signed = (bus.op_code == OP_DIV);
    assign last_iter = (count == COUNT_WIDTH'(BITS - 1));
    assign dz        = (dvs == '0);
    assign writeback = (state == FIXUP) && !bus.flush;

    div_step_unit #(.BITS(BITS)) u_step (
        .rem_in       (rem),
        .quo_in       (quo),
        .dividend_bit (dvd[BITS-1]),
        .divisor      (dvs),
        .rem_out      (rem_step),
        .quo_out      (quo_step)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (acc_div) state_nxt = PREP;
            PREP:    state_nxt = dz ? FIXUP : ITER;
            ITER:    if (last_iter) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // An abort always wins, including over the writeback cycle.
        if (bus.flush && (state != IDLE)) state_nxt = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                count <= '0;
        else if (acc_div)         count <= '0;
        else if (state == ITER)   count <= count + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
            dz_r <= 1'b0;
        end else if (accept) begin
            unique case (bus.op_code)
                OP_MTHI: hi_r <= bus.op_a;
                OP_MTLO: lo_r <= bus.op_a;
                default: dz_r <= 1'b0;
            endcase
        end else if (writeback) begin
            // Divisor zero: dvd was never shifted, so re-signing it restores op_a.
            lo_r <= dz ? '1 : apply_sign(quo, q_neg);
            hi_r <= dz ? apply_sign(dvd, r_neg) : apply_sign(rem, r_neg);
            dz_r <= dz;
        end
    end

    // ---- datapath: operand magnitudes latched at accept, one step per ITER cycle
    always_ff @(posedge clock) begin
        if (acc_div) begin
            dvd   <= magnitude(bus.op_a, is_signed);
            dvs   <= magnitude(bus.op_b, is_signed);
            q_neg <= is_signed && (bus.op_a[BITS-1] ^ bus.op_b[BITS-1]);
            r_neg <= is_signed && bus.op_a[BITS-1];
            rem   <= '0;
            quo   <= '0;
        end else if (state == ITER) begin
            rem   <= rem_step;
            quo   <= quo_step;
            dvd   <= {dvd[BITS-2:0], 1'b0};
        end
    end

    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dz_r;
    assign bus.rd_data     = bus.rd_sel ? hi_r : lo_r;
    assign bus.busy        = (state != IDLE);
    assign bus.stall       = (state != IDLE) && (bus.op_valid || bus.rd_req);
endmodule

// File: tb/tb_mdu_div_controller.sv
// Directed-vector bench for mdu_div_controller: divide results, latency, stall,
// flush and asynchronous reset behaviour.
module tb_mdu_div_controller;
    import mdu_pkg::*;

    localparam int BITS = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mdu_div_controller_if #(.BITS(BITS)) bus();

    mdu_div_controller #(.BITS(BITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one op for exactly one edge; returns 1ns after that accept edge.
    task automatic issue(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clock); #1;
        bus.op_valid = 1'b0;
    endtask

    // Called 1ns after the accept edge of a non-zero-divisor divide.
    task automatic finish_div(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        repeat (BITS + 1) @(posedge clock);
        #1;
        check({tag, "_busy_fixup"}, bus.busy, 1'b1);
        @(posedge clock); #1;
        check({tag, "_lo"}, bus.lo, exp_lo);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_busy_done"}, bus.busy, 1'b0);
        check({tag, "_dz"}, bus.div_by_zero, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cycles;
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = OP_DIV;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.flush    = 1'b0;
        bus.rd_req   = 1'b0;
        bus.rd_sel   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dz", bus.div_by_zero, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        issue(OP_DIV, 32'd100, 32'd7);
        finish_div("div_100_7", 32'd14, 32'd2);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        finish_div("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
        finish_div("divu_max_2", 32'h7FFF_FFFF, 32'd1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_div("div_ovf", 32'h8000_0000, 32'd0);

        // Divide by zero finishes two edges after accept.
        issue(OP_DIV, 32'd5, 32'd0);
        check("dz_busy_prep", bus.busy, 1'b1);
        @(posedge clock); #1;
        check("dz_busy_fixup", bus.busy, 1'b1);
        @(posedge clock); #1;
        check("dz_lo", bus.lo, 32'hFFFF_FFFF);
        check("dz_hi", bus.hi, 32'd5);
        check("dz_flag", bus.div_by_zero, 1'b1);
        check("dz_busy_done", bus.busy, 1'b0);
        issue(OP_DIV, 32'd100, 32'd7);
        check("dz_cleared_on_accept", bus.div_by_zero, 1'b0);
        finish_div("div_after_dz", 32'd14, 32'd2);

        // Read request held across a divide.
        issue(OP_DIV, 32'd100, 32'd7);
        bus.rd_req = 1'b1;
        bus.rd_sel = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!bus.stall) break;
            cycles++;
        end
        check("rd_stall_cycles", cycles, 32'd34);
        check("rd_lo_data", bus.rd_data, 32'd14);
        bus.rd_sel = 1'b1;
        #1;
        check("rd_hi_data", bus.rd_data, 32'd2);
        bus.rd_req = 1'b0;
        @(negedge clock);

        // Second divide presented while busy is held off until busy drops.
        issue(OP_DIV, 32'd100, 32'd7);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_DIV;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd3;
        repeat (BITS + 1) @(posedge clock);
        #1;
        check("hold_stall_fixup", bus.stall, 1'b1);
        @(posedge clock); #1;
        check("hold_first_lo", bus.lo, 32'd14);
        check("hold_busy_gap", bus.busy, 1'b0);
        check("hold_stall_gap", bus.stall, 1'b0);
        @(posedge clock); #1;
        bus.op_valid = 1'b0;
        check("hold_accepted", bus.busy, 1'b1);
        finish_div("hold_9_3", 32'd3, 32'd0);

        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        check("mthi", bus.hi, 32'h0000_1234);
        check("mthi_busy", bus.busy, 1'b0);
        issue(OP_MTLO, 32'h0000_ABCD, 32'd0);
        check("mtlo", bus.lo, 32'h0000_ABCD);

        // Flush at ITER cycle 10.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
        check("flush_iter_busy", bus.busy, 1'b0);
        check("flush_iter_hi", bus.hi, 32'h0000_1234);
        check("flush_iter_lo", bus.lo, 32'h0000_ABCD);

        // Flush during the writeback cycle suppresses writeback.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (BITS + 1) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
        check("flush_fixup_busy", bus.busy, 1'b0);
        check("flush_fixup_hi", bus.hi, 32'h0000_1234);
        check("flush_fixup_lo", bus.lo, 32'h0000_ABCD);

        // Flush in IDLE blocks acceptance.
        bus.flush = 1'b1;
        issue(OP_MTHI, 32'h0000_5555, 32'd0);
        bus.flush = 1'b0;
        check("flush_idle_hi", bus.hi, 32'h0000_1234);

        // Asynchronous reset in the middle of ITER.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_hi", bus.hi, 32'h0);
        check("async_rst_lo", bus.lo, 32'h0);
        check("async_rst_busy", bus.busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(OP_DIV, 32'd9, 32'd3);
        finish_div("post_rst_9_3", 32'd3, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdu_div_controller.md
Name: mdu_div_controller

Overview:
- Sequencer for the integer divide path of the MIPS core.
- Accepts DIV/DIVU/MTHI/MTLO from the execute stage and runs an iterative radix-2 restoring division, one quotient bit per cycle.
- Handles sign pre-/post-fixup, writes LO=quotient and HI=remainder, and stalls the pipeline on MFHI/MFLO or a new op while busy.
- Sits beside the ALU and owns the HI/LO architectural registers.

Parameters:
- BITS, 32, operand/result width.
- COUNT_WIDTH, $clog2(BITS)+1, iteration counter width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  execute stage presents an op this cycle.
- op_code  input  2  00 DIV (signed), 01 DIVU, 10 MTHI, 11 MTLO.
- op_a  input  BITS  dividend / MT source.
- op_b  input  BITS  divisor (ignored for MT).
- flush  input  1  pipeline flush; aborts the in-flight divide.
- rd_req  input  1  MFHI/MFLO in execute.
- rd_sel  input  1  1=HI, 0=LO.
- rd_data  output  BITS  combinational: rd_sel ? hi : lo.
- hi  output  BITS  HI register.
- lo  output  BITS  LO register.
- busy  output  1  divide in progress.
- stall  output  1  busy && (op_valid || rd_req).
- div_by_zero  output  1  sticky flag for the last completed divide; cleared on the next accepted DIV/DIVU.

Behaviour:
- Reset (async, any state, including mid-divide): state=IDLE, hi=lo=0, busy=0, div_by_zero=0, counter=0.
- State machine:
  - IDLE: op accepted when op_valid && !busy && !flush.
  - MT ops complete at the accept edge: hi or lo <= op_a; busy stays 0.
  - DIV/DIVU at accept edge E0: latch |op_a| and |op_b| (magnitudes for DIV; raw values for DIVU), quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB] (both 0 for DIVU), clear remainder and quotient, counter=0. Go to PREP, busy=1.
  - PREP, 1 cycle: if divisor==0, go to FIXUP with dz set; else go to ITER.
  - ITER, BITS cycles: shift the remainder left taking the next dividend MSB; if remainder>=divisor, subtract and shift 1 into the quotient, else shift 0. Increment counter; leave when counter==BITS-1.
  - FIXUP, 1 cycle: negate quotient/remainder per latched signs. Write lo<=quotient, hi<=remainder, div_by_zero<=dz, busy<=0. Return to IDLE.
- Latency:
  - Normal divide: hi/lo updated at edge E0+BITS+2 (34 edges for BITS=32); busy high for BITS+2 cycles after E0.
  - Divide-by-zero: hi/lo updated at E0+2.
- Arithmetic rules:
  - Truncation toward zero; remainder takes the dividend's sign.
  - Magnitudes held in BITS bits unsigned; the remainder register is BITS+1 bits for the compare/subtract.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; no trap.
  - Divide-by-zero gives lo=all ones, hi=op_a (unmodified), div_by_zero=1.
- Handshake and stall:
  - op_valid while busy is not accepted; stall=1 holds the pipeline and the op is re-presented.
  - rd_req while busy gives stall=1. rd_data shows stale hi/lo and must not be consumed until stall drops.
  - The result is readable the cycle after FIXUP.
- Flush:
  - Flush in PREP/ITER/FIXUP: next edge returns to IDLE, busy=0, hi/lo/div_by_zero unchanged.
  - Flush with op_valid in IDLE: op not accepted.
  - Flush and FIXUP in the same cycle: flush wins; no writeback.
- op_valid during the FIXUP cycle is stalled; it is accepted the following cycle.
- stall never depends on flush (no combinational loop through the pipeline).

Decomposition:
- Shared package mdu_pkg: op_code constants (OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO), state enum (IDLE, PREP, ITER, FIXUP), BITS default.
- One sub-module div_step_unit: combinational single restoring step (rem_in, quo_in, dividend_bit, divisor -> rem_out, quo_out).
- The controller holds the FSM, counter, sign fixup, HI/LO and stall.

Test Plan:
- DIV 100/7 -> after 34 cycles lo=14, hi=2, busy low, div_by_zero=0.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIV 5/0 -> at E0+2 lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- Issue DIV 100/7, then hold rd_req (rd_sel=0) -> stall=1 for 34 cycles, then rd_data=14 with stall=0. A second DIV issued during busy is held off, then accepted.
- MTHI 0x1234 at idle -> hi=0x1234 next edge. Start DIV, flush at ITER cycle 10 -> busy=0 next edge, hi still 0x1234.
- Assert reset at ITER cycle 5 -> hi=lo=0, busy=0 immediately (asynchronous). A new DIV 9/3 after release -> lo=3, hi=0.
